// File: rtl/spi_xfer_sequencer_if.sv
// Single-master Wishbone link from the transfer sequencer to the SPI core register port.
interface spi_xfer_sequencer_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [4:0]  wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Round-robin SPI transfer sequencer: programs the SPI core over Wishbone for two requesters,
// polls for completion and returns the received word.
module spi_xfer_sequencer #(
  parameter logic [15:0] CLK_DIV   = 16'd4,
  parameter logic [4:0]  CTRL_MODE = 5'b00010,
  parameter int          MAX_POLLS = 1024
) (
  input  logic                        wb_clk_in,
  input  logic                        wb_rst_in,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [4:0]                  req0_ss,
  input  logic [6:0]                  req0_len,
  input  logic [31:0]                 req0_tx,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [4:0]                  req1_ss,
  input  logic [6:0]                  req1_len,
  input  logic [31:0]                 req1_tx,
  output logic                        rsp0_valid,
  output logic                        rsp1_valid,
  output logic [31:0]                 rsp_data,
  output logic                        rsp_err,
  output logic                        busy,
  spi_xfer_sequencer_if.master        wbm
);

  localparam int         PCNT_W   = $clog2(MAX_POLLS) + 1;
  localparam logic [4:0] ADR_DATA = 5'h00;
  localparam logic [4:0] ADR_CTRL = 5'h10;
  localparam logic [4:0] ADR_DIV  = 5'h14;
  localparam logic [4:0] ADR_SS   = 5'h18;

  typedef enum logic [3:0] {
    IDLE, ARB, WR_DIV, WR_TX, WR_SS, WR_CTRL, POLL, RD_RX, CLR_SS, RESP
  } state_t;

  state_t            state;
  logic              grant;
  logic              rr_last;
  logic              div_done;
  logic              err;
  logic [4:0]        ss_q;
  logic [6:0]        len_q;
  logic [31:0]       tx_q;
  logic [PCNT_W-1:0] poll_cnt;
  logic [PCNT_W-1:0] poll_nxt;
  logic              pick;
  logic              acc_we;
  logic [4:0]        acc_adr;
  logic [31:0]       acc_dat;

  assign wbm.wbm_sel_o = 4'hF;
  assign rsp_err       = err;
  assign poll_nxt      = (poll_cnt == PCNT_W'(MAX_POLLS)) ? poll_cnt : poll_cnt + 1'b1;

  // On a tie the requester that was not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) pick = ~rr_last;
    else                          pick = req1_valid;
  end

  always_comb begin
    acc_we  = 1'b1;
    acc_adr = ADR_DATA;
    acc_dat = '0;
    case (state)
      WR_DIV:  begin acc_adr = ADR_DIV;  acc_dat = {16'd0, CLK_DIV}; end
      WR_TX:   acc_dat = tx_q;
      WR_SS:   begin acc_adr = ADR_SS;   acc_dat = 32'd1 << ss_q; end
      WR_CTRL: begin acc_adr = ADR_CTRL; acc_dat = {18'd0, CTRL_MODE, 1'b1, 1'b0, len_q}; end
      POLL:    begin acc_we = 1'b0; acc_adr = ADR_CTRL; end
      RD_RX:   acc_we = 1'b0;
      CLR_SS:  acc_adr = ADR_SS;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) begin
      state         <= IDLE;
      grant         <= 1'b0;
      rr_last       <= 1'b1;
      div_done      <= 1'b0;
      err           <= 1'b0;
      ss_q          <= '0;
      len_q         <= '0;
      tx_q          <= '0;
      poll_cnt      <= '0;
      req0_ready    <= 1'b0;
      req1_ready    <= 1'b0;
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
      rsp_data      <= '0;
      busy          <= 1'b0;
      wbm.wbm_cyc_o <= 1'b0;
      wbm.wbm_stb_o <= 1'b0;
      wbm.wbm_we_o  <= 1'b0;
      wbm.wbm_adr_o <= '0;
      wbm.wbm_dat_o <= '0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          // A request withdrawn before grant is simply dropped.
          if (req0_valid || req1_valid) begin
            grant      <= pick;
            rr_last    <= pick;
            req0_ready <= ~pick;
            req1_ready <= pick;
            ss_q       <= pick ? req1_ss  : req0_ss;
            len_q      <= pick ? req1_len : req0_len;
            tx_q       <= pick ? req1_tx  : req0_tx;
            rsp_data   <= '0;
            state      <= div_done ? WR_TX : WR_DIV;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WR_DIV, WR_TX, WR_SS, WR_CTRL, POLL, RD_RX, CLR_SS: begin
          if (!wbm.wbm_cyc_o) begin
            wbm.wbm_cyc_o <= 1'b1;
            wbm.wbm_stb_o <= 1'b1;
            wbm.wbm_we_o  <= acc_we;
            wbm.wbm_adr_o <= acc_adr;
            wbm.wbm_dat_o <= acc_dat;
          end else if (wbm.wbm_ack_i) begin
            // Dropping everything on ack yields the mandatory idle cycle before the next access.
            wbm.wbm_cyc_o <= 1'b0;
            wbm.wbm_stb_o <= 1'b0;
            wbm.wbm_we_o  <= 1'b0;
            wbm.wbm_adr_o <= '0;
            wbm.wbm_dat_o <= '0;
            case (state)
              WR_DIV: begin
                div_done <= 1'b1;
                state    <= WR_TX;
              end
              WR_TX:   state <= WR_SS;
              WR_SS:   state <= WR_CTRL;
              WR_CTRL: state <= POLL;
              POLL: begin
                poll_cnt <= poll_nxt;
                if (!wbm.wbm_dat_i[8]) begin
                  state <= RD_RX;
                end else if (poll_nxt == PCNT_W'(MAX_POLLS)) begin
                  err   <= 1'b1;
                  state <= CLR_SS;
                end
              end
              RD_RX: begin
                rsp_data <= wbm.wbm_dat_i;
                state    <= CLR_SS;
              end
              CLR_SS: begin
                rsp0_valid <= ~grant;
                rsp1_valid <= grant;
                state      <= RESP;
              end
              default: ;
            endcase
          end
        end
        RESP: begin
          err      <= 1'b0;
          poll_cnt <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Randomized bench for spi_xfer_sequencer: Wishbone slave stub, requester agents and a
// transaction-level reference model of the expected bus traffic and responses.
module tb_spi_xfer_sequencer;

  localparam int          MAXP    = 6;
  localparam logic [15:0] TB_DIV  = 16'd4;
  localparam logic [4:0]  TB_MODE = 5'b00010;

  typedef struct packed { logic we; logic [4:0] adr; logic [31:0] dat; } bus_op_t;
  typedef struct packed { logic who; logic [31:0] data; logic err; } rsp_t;
  typedef struct packed { logic [4:0] ss; logic [6:0] len; logic [31:0] tx; } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_ss = '0, req1_ss = '0;
  logic [6:0]  req0_len = '0, req1_len = '0;
  logic [31:0] req0_tx = '0, req1_tx = '0;
  logic        rsp0_valid, rsp1_valid, rsp_err, busy;
  logic [31:0] rsp_data;

  spi_xfer_sequencer_if wb ();

  spi_xfer_sequencer #(.CLK_DIV(TB_DIV), .CTRL_MODE(TB_MODE), .MAX_POLLS(MAXP)) dut (
    .wb_clk_in(clk), .wb_rst_in(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ss(req0_ss),
    .req0_len(req0_len), .req0_tx(req0_tx),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ss(req1_ss),
    .req1_len(req1_len), .req1_tx(req1_tx),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .wbm(wb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Slave stub configuration and observation
  int          ack_delay = 0;
  int          go_polls  = 5;
  logic [31:0] rx_xor    = '0;
  int          poll_seen = 0;
  logic [31:0] last_tx   = '0;
  int          bus_viol  = 0;
  bus_op_t     bus_log[$];

  initial begin
    bus_op_t     cur, snap;
    bit          active;
    int          wait_left;
    logic [31:0] rd;
    wb.wbm_ack_i = 1'b0;
    wb.wbm_dat_i = '0;
    active    = 0;
    wait_left = 0;
    snap      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wb.wbm_ack_i = 1'b0;
        wb.wbm_dat_i = '0;
        active       = 0;
        poll_seen    = 0;
      end else if (wb.wbm_ack_i) begin
        wb.wbm_ack_i = 1'b0;
        wb.wbm_dat_i = '0;
        if (wb.wbm_cyc_o || wb.wbm_stb_o) bus_viol++;
      end else if (wb.wbm_cyc_o && wb.wbm_stb_o) begin
        cur = {wb.wbm_we_o, wb.wbm_adr_o, wb.wbm_dat_o};
        if (!active) begin
          active    = 1;
          snap      = cur;
          wait_left = ack_delay;
        end else if (cur !== snap) begin
          bus_viol++;
        end
        if (wb.wbm_sel_o !== 4'hF) bus_viol++;
        if (wait_left == 0) begin
          active       = 0;
          wb.wbm_ack_i = 1'b1;
          if (cur.we) begin
            bus_log.push_back(cur);
            if (cur.adr == 5'h00) last_tx = cur.dat;
            if (cur.adr == 5'h10) poll_seen = 0;
          end else begin
            bus_log.push_back({1'b0, cur.adr, 32'd0});
            if (cur.adr == 5'h10) begin
              poll_seen++;
              rd    = $urandom;
              rd[8] = !(go_polls != 0 && poll_seen >= go_polls);
              wb.wbm_dat_i = rd;
            end else begin
              wb.wbm_dat_i = last_tx ^ rx_xor;
            end
          end
        end else begin
          wait_left--;
        end
      end else if (wb.wbm_cyc_o || wb.wbm_stb_o) begin
        bus_viol++;
      end
    end
  end

  // Requester agents: each presents its queue head until the ready pulse
  req_t q0[$], q1[$];
  int   grant_log[$];
  bit   pulse1 = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (req0_ready) begin
        grant_log.push_back(0);
        if (req0_valid && q0.size() > 0) void'(q0.pop_front());
      end
      if (req1_ready) begin
        grant_log.push_back(1);
        if (req1_valid && q1.size() > 0) void'(q1.pop_front());
      end
      if (q0.size() > 0) begin
        req0_valid = 1'b1; req0_ss = q0[0].ss; req0_len = q0[0].len; req0_tx = q0[0].tx;
      end else begin
        req0_valid = 1'b0;
      end
      if (q1.size() > 0) begin
        req1_valid = 1'b1; req1_ss = q1[0].ss; req1_len = q1[0].len; req1_tx = q1[0].tx;
      end else if (pulse1) begin
        req1_valid = 1'b1; req1_ss = 5'($urandom); req1_len = 7'($urandom); req1_tx = $urandom;
        pulse1 = 0;
      end else begin
        req1_valid = 1'b0;
      end
    end
  end

  rsp_t rsp_log[$];
  initial begin
    forever begin
      @(negedge clk);
      if (rsp0_valid) rsp_log.push_back({1'b0, rsp_data, rsp_err});
      if (rsp1_valid) rsp_log.push_back({1'b1, rsp_data, rsp_err});
    end
  end

  // Reference model: one call per expected transfer, in expected service order
  bus_op_t exp_bus[$];
  rsp_t    exp_rsp[$];
  int      exp_grant[$];
  bit      div_pending = 1;
  int      last_grant  = 1;

  task automatic model_xfer(input int who, input req_t r, input int gp, input logic [31:0] rxx);
    bit ok;
    int n;
    if (div_pending) begin
      exp_bus.push_back({1'b1, 5'h14, 32'(TB_DIV)});
      div_pending = 0;
    end
    exp_bus.push_back({1'b1, 5'h00, r.tx});
    exp_bus.push_back({1'b1, 5'h18, 32'd1 << r.ss});
    exp_bus.push_back({1'b1, 5'h10, 32'(TB_MODE) * 512 + 32'd256 + 32'(r.len)});
    ok = (gp >= 1) && (gp <= MAXP);
    n  = ok ? gp : MAXP;
    for (int i = 0; i < n; i++) exp_bus.push_back({1'b0, 5'h10, 32'd0});
    if (ok) exp_bus.push_back({1'b0, 5'h00, 32'd0});
    exp_bus.push_back({1'b1, 5'h18, 32'd0});
    exp_rsp.push_back({who[0], ok ? (r.tx ^ rxx) : 32'd0, !ok});
    exp_grant.push_back(who);
    last_grant = who;
  endtask

  task automatic clear_logs();
    bus_log.delete(); exp_bus.delete();
    rsp_log.delete(); exp_rsp.delete();
    grant_log.delete(); exp_grant.delete();
    bus_viol = 0;
  endtask

  task automatic finish_scenario(input string tag, input int budget);
    int n;
    n = 0;
    while ((rsp_log.size() < exp_rsp.size() || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(n < budget), 64'd1);
    repeat (3) @(negedge clk);
    check({tag, "_nops"}, bus_log.size(), exp_bus.size());
    for (int i = 0; i < exp_bus.size() && i < bus_log.size(); i++)
      check($sformatf("%s_op%0d", tag, i), bus_log[i], exp_bus[i]);
    check({tag, "_nrsp"}, rsp_log.size(), exp_rsp.size());
    for (int i = 0; i < exp_rsp.size() && i < rsp_log.size(); i++)
      check($sformatf("%s_rsp%0d", tag, i), rsp_log[i], exp_rsp[i]);
    check({tag, "_ngrant"}, grant_log.size(), exp_grant.size());
    for (int i = 0; i < exp_grant.size() && i < grant_log.size(); i++)
      check($sformatf("%s_grant%0d", tag, i), grant_log[i], exp_grant[i]);
    check({tag, "_busproto"}, bus_viol, 0);
    clear_logs();
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.ss  = 5'($urandom);
    r.len = 7'($urandom);
    r.tx  = $urandom;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    req_t a[2], b[2];
    int   first, ia, ib, who, gp, n;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cyc",   wb.wbm_cyc_o, 0);
    check("rst_stb",   wb.wbm_stb_o, 0);
    check("rst_we",    wb.wbm_we_o, 0);
    check("rst_adr",   wb.wbm_adr_o, 0);
    check("rst_dat",   wb.wbm_dat_o, 0);
    check("rst_busy",  busy, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    check("rst_rspv",  {rsp0_valid, rsp1_valid}, 0);
    check("rst_rsp",   {rsp_err, rsp_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed first transfer, DIVIDER written once
    ack_delay = 0; go_polls = 5; rx_xor = 32'hFF;
    r = '{5'd3, 7'd8, 32'hA5};
    q0.push_back(r);
    model_xfer(0, r, 5, 32'hFF);
    finish_scenario("single", 2000);

    ack_delay = 1; gp = $urandom_range(1, MAXP); go_polls = gp; rx_xor = $urandom;
    r = rnd_req();
    q1.push_back(r);
    model_xfer(1, r, gp, rx_xor);
    finish_scenario("second", 2000);

    // Both requesters continuously valid: strict alternation, echo data
    ack_delay = 0; go_polls = 2; rx_xor = '0;
    for (int k = 0; k < 2; k++) begin
      a[k] = rnd_req(); b[k] = rnd_req();
      q0.push_back(a[k]); q1.push_back(b[k]);
    end
    first = 1 - last_grant; ia = 0; ib = 0;
    for (int k = 0; k < 4; k++) begin
      who = (first + k) % 2;
      if (who == 0) begin model_xfer(0, a[ia], 2, 32'd0); ia++; end
      else          begin model_xfer(1, b[ib], 2, 32'd0); ib++; end
    end
    finish_scenario("alt", 4000);

    ack_delay = 0; go_polls = 0; rx_xor = $urandom;
    r = rnd_req(); q0.push_back(r); model_xfer(0, r, 0, rx_xor);
    finish_scenario("timeout", 2000);

    go_polls = MAXP;
    r = rnd_req(); q1.push_back(r); model_xfer(1, r, MAXP, rx_xor);
    finish_scenario("lastpoll", 2000);

    ack_delay = 3; gp = $urandom_range(1, MAXP); go_polls = gp; rx_xor = $urandom;
    r = rnd_req(); q0.push_back(r); model_xfer(0, r, gp, rx_xor);
    finish_scenario("slow", 4000);

    for (int t = 0; t < 10; t++) begin
      ack_delay = $urandom_range(0, 3);
      gp = $urandom_range(0, MAXP + 1); go_polls = gp;
      rx_xor = $urandom;
      who = $urandom_range(0, 1);
      r = rnd_req();
      if (who == 0) q0.push_back(r); else q1.push_back(r);
      model_xfer(who, r, gp, rx_xor);
      finish_scenario("rand", 4000);
    end

    // Reset in the middle of a CTRL poll
    ack_delay = 1; go_polls = 0;
    r = rnd_req(); q0.push_back(r);
    n = 0;
    while (!(wb.wbm_cyc_o && !wb.wbm_we_o && wb.wbm_adr_o == 5'h10) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reach_poll", 64'(n < 500), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_cyc",  wb.wbm_cyc_o, 0);
    check("midrst_stb",  wb.wbm_stb_o, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    clear_logs();
    q0.delete(); q1.delete();
    div_pending = 1; last_grant = 1;
    rst = 1'b0;
    @(negedge clk);
    go_polls = 3; rx_xor = $urandom;
    r = rnd_req(); q0.push_back(r); model_xfer(0, r, 3, rx_xor);
    finish_scenario("after_rst", 2000);

    // Short req1 pulse while busy must be ignored
    ack_delay = 2; go_polls = MAXP; rx_xor = $urandom;
    r = rnd_req(); q0.push_back(r); model_xfer(0, r, MAXP, rx_xor);
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pulse_busy", 64'(n < 100), 64'd1);
    repeat (4) @(negedge clk);
    pulse1 = 1;
    finish_scenario("pulse", 4000);
    repeat (20) @(negedge clk);
    check("pulse_idle",     busy, 0);
    check("pulse_no_grant", grant_log.size(), 0);
    check("pulse_no_rsp",   rsp_log.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
